// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the frame constants, the default bit period and the receiver's state
// encoding. With UART_RX_PARITY_EN defined, the receiver gains a PARITY state,
// which needs a 3-bit state code.
package uart_pkg;
  localparam int   DEFAULT_BIT_TICKS = 10417;  // 100 MHz / 9600 baud
  localparam int   DATA_BITS         = 8;
  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;

`ifdef UART_RX_PARITY_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  typedef logic [STATE_W-1:0] rx_state_t;
  localparam rx_state_t S_IDLE   = rx_state_t'(0);
  localparam rx_state_t S_START  = rx_state_t'(1);
  localparam rx_state_t S_DATA   = rx_state_t'(2);
  localparam rx_state_t S_STOP   = rx_state_t'(3);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t S_PARITY = rx_state_t'(4);
`endif
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side handshake of the UART receiver.
//   rd_ack     consumer -> rx : byte taken, clear valid/overrun
//   data_out   rx -> consumer : last good byte
//   valid      rx -> consumer : data_out holds an unread byte
//   busy       rx -> consumer : a frame is in progress
//   frame_err  rx -> consumer : 1-cycle pulse, stop bit sampled low
//   overrun    rx -> consumer : sticky, unread byte was overwritten
//   parity_err rx -> consumer : 1-cycle pulse (only with UART_RX_PARITY_EN)
// master = receiver, slave = consumer.
interface uart_rx_if;
  import uart_pkg::*;
  logic                 rd_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    input  rd_ack,
    output data_out, valid, busy, frame_err, overrun
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport slave (
    output rd_ack,
    input  data_out, valid, busy, frame_err, overrun
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous RX pin plus a
// falling-edge detector on the synchronized line.
//   clk, arst_n (async, active-low), rst (sync clear)
//   rx_i    raw serial line
//   rx_s_o  synchronized line
//   fall_o  rx_s went 1 -> 0 this cycle
// All flops reset to 1 (idle line), so reset itself never looks like an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic arst_n,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);
  // [0] meta flop, [1] rx_s, [2] rx_s delayed one cycle
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  sh_q <= '1;
    else if (rst) sh_q <= '1;
    else          sh_q <= {sh_q[1:0], rx_i};
  end

  assign rx_s_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ack holding register.
//   clk, arst_n (async, active-low), rst (sync clear, same effect as arst_n)
//   RX   asynchronous serial input, idle high
//   bus  uart_rx_if.master (rd_ack in; data_out/valid/busy/frame_err/overrun out)
// Each bit is sampled at its mid-point: a half-bit count from the start edge,
// then whole-bit counts. The receiver returns to IDLE at the stop-bit sample,
// half a bit early, so back-to-back frames are accepted.
// Optional: `define UART_RX_PARITY_EN adds parameter PARITY_ODD, a PARITY
// state between DATA and STOP, and a parity_err pulse on the interface.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_TICKS  = DEFAULT_BIT_TICKS,  // must be >= 4
  parameter int HALF_TICKS = BIT_TICKS / 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      rst,
  input  logic      RX,
  uart_rx_if.master bus
);
  localparam int             CW          = $clog2(BIT_TICKS);
  localparam logic [CW-1:0]  BIT_RELOAD  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0]  HALF_RELOAD = CW'(HALF_TICKS - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .rst    (rst),
    .rx_i   (RX),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 over_q, over_d;
  logic                 fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                 pe_q, pe_d;
  logic                 pbad_q, pbad_d;
`endif

  logic tick;
  assign tick = (cnt_q == '0);

  // state and datapath registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE; cnt_q <= '0; idx_q <= '0; sh_q <= '0;
      data_q <= '0; valid_q <= 1'b0; over_q <= 1'b0; fe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0; pbad_q <= 1'b0;
`endif
    end else if (rst) begin
      state_q <= S_IDLE; cnt_q <= '0; idx_q <= '0; sh_q <= '0;
      data_q <= '0; valid_q <= 1'b0; over_q <= 1'b0; fe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0; pbad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; idx_q <= idx_d; sh_q <= sh_d;
      data_q <= data_d; valid_q <= valid_d; over_q <= over_d; fe_q <= fe_d;
`ifdef UART_RX_PARITY_EN
      pe_q <= pe_d; pbad_q <= pbad_d;
`endif
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      // a start bit that is high again at its mid-point was a glitch
      S_START: if (tick) state_d = (rx_s == START_BIT) ? S_DATA : S_IDLE;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick && idx_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
`else
      S_DATA:  if (tick && idx_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
`endif
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath next values and outputs
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    over_d  = over_q;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d    = 1'b0;
    pbad_d  = pbad_q;
`endif
    // an ack cancels both flags; a byte completing this cycle overrides below
    if (bus.rd_ack) begin
      valid_d = 1'b0;
      over_d  = 1'b0;
    end
    case (state_q)
      S_IDLE: if (fall) begin
        cnt_d = HALF_RELOAD;
        idx_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d = 1'b0;
`endif
      end
      S_START: begin
        if (tick) begin
          cnt_d = BIT_RELOAD;
          idx_d = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_DATA: begin
        if (tick) begin
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};  // LSB arrives first
          cnt_d = BIT_RELOAD;
          if (idx_q != 3'(DATA_BITS - 1)) idx_d = idx_q + 3'd1;
        end else cnt_d = cnt_q - 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          pbad_d = rx_s ^ (^sh_q) ^ PARITY_ODD;
          cnt_d  = BIT_RELOAD;
        end else cnt_d = cnt_q - 1'b1;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (rx_s != STOP_BIT) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (pbad_q) pe_d = 1'b1;
`endif
          else begin
            data_d  = sh_q;
            valid_d = 1'b1;
            if (valid_q && !bus.rd_ack) over_d = 1'b1;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase

    bus.data_out  = data_q;
    bus.valid     = valid_q;
    bus.busy      = (state_q != S_IDLE);
    bus.frame_err = fe_q;
    bus.overrun   = over_q;
`ifdef UART_RX_PARITY_EN
    bus.parity_err = pe_q;
`endif
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at BIT_TICKS=16.
// Directed table of frames, hand-written corner sequences (glitch, resets,
// ack behaviour, parity when UART_RX_PARITY_EN is defined) and random frames
// checked against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BT   = 16;
  localparam int HT   = BT / 2;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // cycle index within a frame (counted from the negedge driving the start
  // bit) whose following posedge samples the stop bit: half bit plus
  // NB-1 whole bits plus the 2-cycle synchronizer
  localparam int SC = (NB - 1) * BT + HT + 2;

  logic clk = 1'b0, arst_n = 1'b0, rst = 1'b0, rx = 1'b1;
  int   checks = 0, errors = 0;
  int   fe_cnt = 0, pe_cnt = 0;

  // frame-level reference model
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0, m_over = 1'b0;
  int         m_fe = 0, m_pe = 0;

  uart_rx_if bus ();

  uart_rx #(.BIT_TICKS(BT)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rst    (rst),
    .RX     (rx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err) pe_cnt++;
`endif
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop, input bit par_ok, input int ack_at);
    bit coinc;
    coinc = (ack_at == SC);
    if (ack_at >= 0 && ack_at < SC) model_clear();
    if (!stop) begin
      m_fe++;
      if (coinc) model_clear();
    end else if (!par_ok) begin
      m_pe++;
      if (coinc) model_clear();
    end else begin
      m_over  = coinc ? 1'b0 : (m_over | m_valid);
      m_data  = d;
      m_valid = 1'b1;
    end
    if (ack_at > SC) model_clear();
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, bus.valid, m_valid);
    check({tag, ".data"}, bus.data_out, m_data);
    check({tag, ".overrun"}, bus.overrun, m_over);
    check({tag, ".frame_err_pulses"}, fe_cnt, m_fe);
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_err_pulses"}, pe_cnt, m_pe);
`endif
  endtask

  // drives one frame, pulsing rd_ack during cycle ack_at (-1: none)
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok,
                            input int ack_at, output bit busy_ok);
    logic [NB-1:0] bits;
    bits[0]   = START_BIT;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^d) ^ PODD ^ ~par_ok;
`endif
    bits[NB-1] = stop;
    busy_ok = 1'b1;
    for (int c = 0; c < NB * BT; c++) begin
      @(negedge clk);
      rx = bits[c / BT];
      bus.rd_ack = (c == ack_at);
      if (c >= 4 && c <= SC && !bus.busy) busy_ok = 1'b0;
    end
    bus.rd_ack = 1'b0;
    if (!stop) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk); bus.rd_ack = 1'b1;
    @(negedge clk); bus.rd_ack = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         ack_at;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_over;
    int         exp_fe;
  } vec_t;

  initial begin
    vec_t vt[6];
    bit   bok;
    int   fe0;

    bus.rd_ack = 1'b0;
    idle(3);
    check("reset.valid", bus.valid, 1'b0);
    check("reset.data", bus.data_out, 8'h00);
    check("reset.busy", bus.busy, 1'b0);
    check("reset.overrun", bus.overrun, 1'b0);
    check("reset.frame_err", bus.frame_err, 1'b0);
    arst_n = 1'b1;
    idle(5);

    vt[0] = '{8'hA5, 1'b1, -1, 10, 8'hA5, 1'b1, 1'b0, 0};
    vt[1] = '{8'h3C, 1'b0, 20, 10, 8'hA5, 1'b0, 1'b0, 1};
    vt[2] = '{8'h01, 1'b1, -1,  0, 8'h01, 1'b1, 1'b0, 0};
    vt[3] = '{8'h02, 1'b1, -1,  0, 8'h02, 1'b1, 1'b1, 0};
    vt[4] = '{8'h03, 1'b1, SC,  5, 8'h03, 1'b1, 1'b0, 0};
    vt[5] = '{8'h80, 1'b0, SC, 10, 8'h03, 1'b0, 1'b0, 1};
    foreach (vt[i]) begin
      fe0 = fe_cnt;
      send_frame(vt[i].data, vt[i].stop, 1'b1, vt[i].ack_at, bok);
      model_frame(vt[i].data, vt[i].stop, 1'b1, vt[i].ack_at);
      check($sformatf("vec%0d.busy", i), bok, 1'b1);
      check($sformatf("vec%0d.data", i), bus.data_out, vt[i].exp_data);
      check($sformatf("vec%0d.valid", i), bus.valid, vt[i].exp_valid);
      check($sformatf("vec%0d.overrun", i), bus.overrun, vt[i].exp_over);
      check($sformatf("vec%0d.frame_err", i), fe_cnt - fe0, vt[i].exp_fe);
      idle(vt[i].gap);
    end

    // glitch: 4 low cycles must abort in START with no effect
    fe0 = fe_cnt;
    @(negedge clk); rx = 1'b0;
    idle(4); rx = 1'b1;
    idle(2);
    check("glitch.busy_hi", bus.busy, 1'b1);
    idle(6);
    check("glitch.busy_lo", bus.busy, 1'b0);
    idle(30);
    check("glitch.valid", bus.valid, 1'b0);
    check("glitch.frame_err", fe_cnt - fe0, 0);

    // back-to-back then a single ack clears both flags; a second ack is a no-op
    send_frame(8'h11, 1'b1, 1'b1, -1, bok); model_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1, bok); model_frame(8'h22, 1'b1, 1'b1, -1);
    check("b2b.overrun", bus.overrun, 1'b1);
    pulse_ack();
    check("ack.valid", bus.valid, 1'b0);
    check("ack.overrun", bus.overrun, 1'b0);
    pulse_ack();
    check("ack_idle.data", bus.data_out, 8'h22);
    check("ack_idle.valid", bus.valid, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, -1, bok); model_frame(8'h33, 1'b1, 1'b1, -1);
    idle(5);

    // async reset during data bit 4 of 0xFF
    for (int c = 0; c < 5 * BT + 5; c++) begin
      @(negedge clk); rx = (c < BT) ? 1'b0 : 1'b1;
    end
    @(negedge clk); arst_n = 1'b0;
    #1;
    check("arst.busy", bus.busy, 1'b0);
    check("arst.valid", bus.valid, 1'b0);
    check("arst.data", bus.data_out, 8'h00);
    check("arst.overrun", bus.overrun, 1'b0);
    @(negedge clk); arst_n = 1'b1;
    m_data = 8'h00; model_clear();
    idle(40);
    send_frame(8'h55, 1'b1, 1'b1, -1, bok); model_frame(8'h55, 1'b1, 1'b1, -1);
    compare_model("after_arst");
    idle(5);

    // synchronous reset during data bit 2
    for (int c = 0; c < 3 * BT + 5; c++) begin
      @(negedge clk); rx = (c < BT) ? 1'b0 : 1'b1;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("srst.busy", bus.busy, 1'b0);
    check("srst.valid", bus.valid, 1'b0);
    check("srst.data", bus.data_out, 8'h00);
    m_data = 8'h00; model_clear();
    idle(60);
    compare_model("after_srst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1, bok); model_frame(8'h07, 1'b1, 1'b0, -1);
    check("par_bad.valid", bus.valid, 1'b0);
    compare_model("par_bad");
    idle(5);
    send_frame(8'h07, 1'b1, 1'b1, -1, bok); model_frame(8'h07, 1'b1, 1'b1, -1);
    check("par_ok.data", bus.data_out, 8'h07);
    check("par_ok.valid", bus.valid, 1'b1);
    idle(5);
    send_frame(8'h5A, 1'b0, 1'b0, -1, bok); model_frame(8'h5A, 1'b0, 1'b0, -1);
    compare_model("par_and_frame");
    idle(5);
`endif

    // random frames against the model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit stop, pok;
      int ack_at, sel;
      d    = 8'($urandom);
      stop = ($urandom % 5) != 0;
`ifdef UART_RX_PARITY_EN
      pok  = ($urandom % 4) != 0;
`else
      pok  = 1'b1;
`endif
      sel = $urandom % 4;
      ack_at = (sel == 0) ? -1 : (sel == 1) ? SC : $urandom_range(0, NB * BT - 2);
      send_frame(d, stop, pok, ack_at, bok);
      model_frame(d, stop, pok, ack_at);
      compare_model($sformatf("rand%0d", n));
      if (($urandom % 3) != 0) idle($urandom_range(1, 20));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
